// File: rtl/mdu_ctrl_if.sv
// Bus between the EX-stage MDU sequencer and the mul/div units.
// The master side is the sequencer; the slave side is the arithmetic units.
interface mdu_ctrl_if;
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;

  modport master (
    output mul_signed, mul_ina, mul_inb,
    output div_start, div_signed, div_opdata1,
    output div_opdata2, div_annul,
    input  mul_result, div_result, div_ready
  );

  modport slave (
    input  mul_signed, mul_ina, mul_inb,
    input  div_start, div_signed, div_opdata1,
    input  div_opdata2, div_annul,
    output mul_result, div_result, div_ready
  );
endinterface

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer owning HI/LO.
// Launches mul/div ops, stalls EX until done, handles MTHI/MTLO.
module mdu_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [2:0]  md_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  mdu_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE, MUL_WAIT, DIV_WAIT, DONE
  } state_t;

  state_t r_state, w_next;

  logic [31:0]      r_a, r_b, r_hi, r_lo;
  logic             r_sgn;
  logic [CNT_W-1:0] r_cnt;

  logic        w_mul_op, w_div_op, w_latch;
  logic        w_wr_hi, w_wr_lo;
  logic [31:0] w_hi_d, w_lo_d;
  logic        w_in_mul, w_in_div;

  assign w_mul_op = (md_op == 3'd1) || (md_op == 3'd2);
  assign w_div_op = (md_op == 3'd3) || (md_op == 3'd4);
  assign w_in_mul = (r_state == MUL_WAIT);
  assign w_in_div = (r_state == DIV_WAIT);

  always_comb begin
    w_next        = r_state;
    stall_req     = 1'b0;
    bus.div_start = 1'b0;
    bus.div_annul = 1'b0;
    w_latch       = 1'b0;
    w_wr_hi       = 1'b0;
    w_wr_lo       = 1'b0;
    w_hi_d        = r_hi;
    w_lo_d        = r_lo;
    unique case (r_state)
      IDLE: begin
        if (!flush) begin
          if (w_mul_op || w_div_op) begin
            stall_req = 1'b1;
            w_latch   = 1'b1;
            w_next    = w_mul_op ? MUL_WAIT : DIV_WAIT;
          end else if (md_op == 3'd5) begin
            w_wr_hi = 1'b1;
            w_hi_d  = src1;
          end else if (md_op == 3'd6) begin
            w_wr_lo = 1'b1;
            w_lo_d  = src1;
          end
        end
      end
      MUL_WAIT: begin
        stall_req = 1'b1;
        if (!flush && r_cnt == '0) begin
          w_next  = DONE;
          w_wr_hi = 1'b1;
          w_wr_lo = 1'b1;
          w_hi_d  = bus.mul_result[63:32];
          w_lo_d  = bus.mul_result[31:0];
        end
      end
      DIV_WAIT: begin
        stall_req = 1'b1;
        if (flush) begin
          bus.div_annul = 1'b1;
        end else if (bus.div_ready) begin
          w_next  = DONE;
          w_wr_hi = 1'b1;
          w_wr_lo = 1'b1;
          w_hi_d  = bus.div_result[63:32];
          w_lo_d  = bus.div_result[31:0];
        end else begin
          bus.div_start = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // flush beats every completion and launch
    if (flush) begin
      w_next    = IDLE;
      stall_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sgn <= 1'b0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_latch) begin
        r_a   <= src1;
        r_b   <= src2;
        r_sgn <= (md_op == 3'd1) || (md_op == 3'd3);
        r_cnt <= CNT_W'(MUL_LAT - 1);
      end else if (w_in_mul && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_wr_hi) r_hi <= w_hi_d;
      if (w_wr_lo) r_lo <= w_lo_d;
    end
  end

  assign bus.mul_signed  = w_in_mul & r_sgn;
  assign bus.mul_ina     = w_in_mul ? r_a : '0;
  assign bus.mul_inb     = w_in_mul ? r_b : '0;
  assign bus.div_signed  = w_in_div & r_sgn;
  assign bus.div_opdata1 = w_in_div ? r_a : '0;
  assign bus.div_opdata2 = w_in_div ? r_b : '0;

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl with behavioural mul/div units.
// Monitor pops expected HI/LO whenever EX stall is released.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src1 = 32'd0;
  logic [31:0] src2 = 32'd0;
  logic        stall_req;
  logic [31:0] hi, lo;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MUL_LAT(2), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .md_op(md_op), .src1(src1), .src2(src2),
    .stall_req(stall_req), .hi(hi), .lo(lo),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one-stage registered multiplier
  always @(posedge clk)
    bus.mul_result <=
      {{32{bus.mul_signed & bus.mul_ina[31]}}, bus.mul_ina} *
      {{32{bus.mul_signed & bus.mul_inb[31]}}, bus.mul_inb};

  int          dcnt = 0;
  int          div_lat = 33;
  logic [63:0] div_res = 64'd0;
  assign bus.div_ready  = (dcnt == div_lat);
  assign bus.div_result = div_res;
  always @(posedge clk) begin
    if (bus.div_ready || bus.div_annul) dcnt <= 0;
    else if (bus.div_start)             dcnt <= dcnt + 1;
  end

  logic [63:0] exp_q[$];
  int   start_cyc = 0;
  int   annul_cyc = 0;
  int   launches = 0;
  logic prev_stall = 1'b0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    #3;
    if (resetn) begin
      if (prev_stall && !stall_req) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard: unexpected release hi/lo %h_%h",
                   hi, lo);
        end else begin
          check("hilo", {hi, lo}, exp_q.pop_front());
        end
      end
      if (bus.div_start) start_cyc++;
      if (bus.div_annul) annul_cyc++;
      if (bus.div_start && !prev_start) launches++;
    end
    prev_stall = stall_req;
    prev_start = bus.div_start;
  end

  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int n);
    md_op = op;
    src1  = a;
    src2  = b;
    n = 0;
    #1;
    while (stall_req && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  int n;
  int k;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_div_start", 64'(bus.div_start), 64'd0);
    check("rst_div_annul", 64'(bus.div_annul), 64'd0);
    check("rst_mul_ina", 64'(bus.mul_ina), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
    run_op(3'd1, 32'hFFFFFFFD, 32'd5, n);
    check("mult_stall_cycles", 64'(n), 64'd3);
    @(negedge clk);
    md_op = 3'd0;
    #1;
    check("idle_stall", 64'(stall_req), 64'd0);
    @(negedge clk);

    exp_q.push_back(64'h00000004_FFFFFFF1);
    run_op(3'd2, 32'hFFFFFFFD, 32'd5, n);
    check("multu_stall_cycles", 64'(n), 64'd3);
    @(negedge clk);
    md_op = 3'd0;
    @(negedge clk);

    div_lat = 33;
    div_res = {32'd1, 32'hFFFFFFFD};
    start_cyc = 0;
    exp_q.push_back({32'd1, 32'hFFFFFFFD});
    run_op(3'd3, 32'd7, 32'hFFFFFFFE, n);
    check("div_stall_cycles", 64'(n), 64'd35);
    check("div_start_cycles", 64'(start_cyc), 64'd33);

    @(negedge clk);
    md_op = 3'd5;
    src1  = 32'h1234;
    #1;
    check("mthi_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    md_op = 3'd6;
    src1  = 32'h5678;
    #1;
    check("mtlo_stall", 64'(stall_req), 64'd0);
    check("mthi_hi", 64'(hi), 64'h1234);
    @(negedge clk);
    md_op = 3'd0;
    #1;
    check("mt_hilo", {hi, lo}, {32'h1234, 32'h5678});

    @(negedge clk);
    div_lat = 33;
    annul_cyc = 0;
    exp_q.push_back({32'h1234, 32'h5678});
    md_op = 3'd3;
    src1  = 32'd7;
    src2  = 32'hFFFFFFFE;
    @(negedge clk);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    md_op = 3'd0;
    #1;
    check("flush_annul", 64'(bus.div_annul), 64'd1);
    check("flush_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("post_flush_annul", 64'(bus.div_annul), 64'd0);
    check("post_flush_start", 64'(bus.div_start), 64'd0);
    check("post_flush_stall", 64'(stall_req), 64'd0);
    repeat (2) @(negedge clk);
    check("annul_pulses", 64'(annul_cyc), 64'd1);

    div_lat = 4;
    div_res = 64'hDEADBEEF_CAFEF00D;
    exp_q.push_back({32'h1234, 32'h5678});
    md_op = 3'd4;
    src1  = 32'd100;
    src2  = 32'd7;
    k = 0;
    @(negedge clk);
    #1;
    while (!bus.div_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("ready_seen", 64'(bus.div_ready), 64'd1);
    flush = 1'b1;
    md_op = 3'd0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_ready_hilo", {hi, lo}, {32'h1234, 32'h5678});
    @(negedge clk);

    div_lat = 3;
    div_res = {32'd2, 32'd14};
    launches = 0;
    exp_q.push_back({32'd2, 32'd14});
    exp_q.push_back({32'd2, 32'd14});
    run_op(3'd4, 32'd100, 32'd7, n);
    check("divu1_stall_cycles", 64'(n), 64'd5);
    @(negedge clk);
    run_op(3'd4, 32'd100, 32'd7, n);
    check("divu2_stall_cycles", 64'(n), 64'd5);
    @(negedge clk);
    md_op = 3'd0;
    repeat (3) @(negedge clk);
    #1;
    check("divu_launches", 64'(launches), 64'd2);
    check("divu_hilo", {hi, lo}, {32'd2, 32'd14});
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
